// File: rtl/bcd_display_driver.sv
// Sequential double-dabble binary-to-BCD converter driving NUM_DIGITS active-low 7-segment displays.
// Optional build macro: BCD_DISPLAY_LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 always shown).
module bcd_display_driver #(
    parameter int BIN_WIDTH  = 10,
    parameter int NUM_DIGITS = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [BIN_WIDTH-1:0]    value,
    input  logic                    enable,
    output logic                    busy,
    output logic                    done,
    output logic                    overflow,
    output logic [7*NUM_DIGITS-1:0] hex
);

    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int HEX_W = 7 * NUM_DIGITS;
    localparam int CNT_W = $clog2(BIN_WIDTH + 1);
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    function automatic logic [31:0] pow10(input int n);
        logic [31:0] r;
        r = 32'd1;
        for (int i = 0; i < n; i++) r = r * 32'd10;
        return r;
    endfunction

    localparam logic [31:0] LIMIT = pow10(NUM_DIGITS);

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = SEG_BLANK;
        endcase
    endfunction

    // One double-dabble step: add 3 to every nibble >= 5, then shift in the next binary bit.
    // The bit shifted out of the top nibble is dropped; the overflow flag covers that case.
    function automatic logic [BCD_W-1:0] dabble_step(input logic [BCD_W-1:0] b, input logic in_bit);
        logic [BCD_W-1:0] adj;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            adj[4*k +: 4] = (b[4*k +: 4] >= 4'd5) ? b[4*k +: 4] + 4'd3 : b[4*k +: 4];
        end
        return (adj << 1) | BCD_W'(in_bit);
    endfunction

    typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

    state_t               state, state_next;
    logic [BIN_WIDTH-1:0] shift_q;
    logic [BCD_W-1:0]     bcd_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 ovf_pending_q;
    logic [HEX_W-1:0]     pattern_q;
    logic [HEX_W-1:0]     pattern_new;
    logic [3:0]           digit;
    logic [31:0]          value_ext;
`ifdef BCD_DISPLAY_LEADING_ZERO_BLANK_EN
    logic                 nonzero_seen;
`endif

    assign value_ext = 32'(value);
    assign busy      = (state == SHIFT);
    assign done      = (state == FINISH);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (cnt_q == CNT_W'(1)) state_next = FINISH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Conversion datapath: load on accepted start, one bit per SHIFT cycle.
    always_ff @(posedge clk) begin
        case (state)
            IDLE: begin
                if (start) begin
                    shift_q       <= value;
                    bcd_q         <= '0;
                    cnt_q         <= CNT_W'(BIN_WIDTH);
                    ovf_pending_q <= (value_ext >= LIMIT);
                end
            end
            SHIFT: begin
                bcd_q   <= dabble_step(bcd_q, shift_q[BIN_WIDTH-1]);
                shift_q <= shift_q << 1;
                cnt_q   <= cnt_q - CNT_W'(1);
            end
            default: ;
        endcase
    end

    // Display pattern built from the finished BCD digits, most significant digit first.
    always_comb begin
        pattern_new = '0;
        digit       = '0;
`ifdef BCD_DISPLAY_LEADING_ZERO_BLANK_EN
        nonzero_seen = 1'b0;
`endif
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            digit = bcd_q[4*k +: 4];
            pattern_new[7*k +: 7] = seg7(digit);
`ifdef BCD_DISPLAY_LEADING_ZERO_BLANK_EN
            if (digit != 4'd0) begin
                nonzero_seen = 1'b1;
            end else if (!nonzero_seen && k != 0) begin
                pattern_new[7*k +: 7] = SEG_BLANK;
            end
`endif
        end
        if (ovf_pending_q) pattern_new = {NUM_DIGITS{SEG_DASH}};
    end

    // Control, stored pattern and display registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            overflow  <= 1'b0;
            pattern_q <= {HEX_W{1'b1}};
            hex       <= {HEX_W{1'b1}};
        end else begin
            state <= state_next;
            if (state == FINISH) begin
                pattern_q <= pattern_new;
                overflow  <= ovf_pending_q;
            end
            if (enable) begin
                hex <= (state == FINISH) ? pattern_new : pattern_q;
            end
        end
    end

endmodule

// File: doc/bcd_display_driver.md
Name: bcd_display_driver

Overview:
- Parametrised successor to the single-digit BCD-to-7-segment decoder.
- Converts a BIN_WIDTH-bit unsigned binary value to NUM_DIGITS decimal digits using a sequential double-dabble (shift-add-3) engine, one bit per clock.
- Drives NUM_DIGITS active-low 7-segment displays from registers.
- Handles start/busy/done handshake, display enable/hold, overflow indication and reset blanking.
- Sits between score/timer counters and the board HEX outputs.

Parameters:
- BIN_WIDTH, 10, width of binary input; legal range 1..31.
- NUM_DIGITS, 3, number of decimal digits/displays; legal range 1..9.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a conversion of value; sampled only in IDLE.
- value  input  BIN_WIDTH  unsigned binary to display; latched on accepted start.
- enable  input  1  display update enable; 0 freezes hex outputs.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse on conversion completion.
- overflow  output  1  high when the last converted value was at least 10^NUM_DIGITS.
- hex  output  7*NUM_DIGITS  segments, active-low; digit k (k=0 is least significant) on hex[7k+6:7k], bit order {g,f,e,d,c,b,a}.

Behaviour:
- Reset: synchronous, active-high; overrides all other inputs in the same cycle. After reset:
  - state=IDLE; busy=0, done=0, overflow=0.
  - hex = all ones (all displays blank); stored display pattern = all blank.
- Reset asserted mid-conversion aborts the conversion; nothing is written to the display.
- Segment encoding per digit:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001.
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - blank=1111111, dash=0111111.
- FSM states: IDLE, SHIFT, FINISH.
- IDLE:
  - start=1 latches value into the shift register, clears the BCD register (4*NUM_DIGITS bits) and loads bit counter = BIN_WIDTH.
  - Computes overflow_pending = (value >= 10^NUM_DIGITS), using 32-bit comparison.
  - Next state SHIFT; busy=1 from the following cycle.
- SHIFT, one cycle per bit:
  - Every BCD nibble >= 5 gets +3.
  - Then {bcd, shift} shifts left by 1, with the shift MSB entering bcd LSB.
  - Counter decrements; when the counter reaches 0 after a shift, next state is FINISH.
  - BCD bits shifted out of the top are discarded; the overflow flag covers this case.
- FINISH (1 cycle):
  - Stored pattern = per-digit encoding, or all dash if overflow_pending.
  - overflow <= overflow_pending; done=1 for this cycle; busy=0.
  - Next state IDLE.
- Latency: start accepted at edge 0 -> done high and busy low at cycle BIN_WIDTH+1. A new start is accepted on the cycle after done.
- start while busy or in FINISH: ignored, not queued.
- Hex register update:
  - At the FINISH edge, if enable=1, hex loads the new pattern on that same edge.
  - Otherwise hex holds its value, and the stored pattern is loaded on the first edge where enable=1.
  - While enable=1 and no conversion is finishing, hex tracks the stored pattern.
- overflow holds until the next FINISH or reset; it is not gated by enable.

Optional Feature:
- Macro: BCD_DISPLAY_LEADING_ZERO_BLANK_EN.
- Defined: when building the stored pattern, every zero digit more significant than the most significant nonzero digit is blank (1111111). Digit 0 always shows. Overflow dashes are unaffected.
- Undefined: all digits are shown, including leading zeros.

Test Plan (BIN_WIDTH=10, NUM_DIGITS=3, enable=1 unless stated):
- Reset for 2 cycles -> hex=21'h1FFFFF, busy=0, done=0, overflow=0.
- start with value=999 -> busy=1 for 10 cycles, done pulse at cycle 11; hex = 0010000 x3; overflow=0.
- start with value=7 -> macro undefined: hex = {1000000,1000000,1111000}; macro defined: hex = {1111111,1111111,1111000}.
- start with value=1000 -> overflow=1; hex = 0111111 x3. Follow with value=42 -> overflow=0, hex digit1=0011001, digit0=0100100.
- start with value=255, start re-pulsed at cycle 4 with value=1 -> second start ignored; hex shows 2,5,5; exactly one done pulse.
- enable=0 during conversion of 128 -> hex unchanged at done. Raise enable 3 cycles later -> hex shows 1,2,8 on that edge. Reset at cycle 5 of a further conversion -> no done pulse; hex blank.
